// File: rtl/move_ctrl_pkg.sv
// ============================================================================
// Module   : ttt_pkg
// Purpose  : Shared types and constants for the 3x3 board move controller:
//            cell encoding, winner codes, controller states and the table of
//            eight winning lines.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ttt_pkg;

  // Board geometry: cell i lives at gBoard[2i+1:2i]
  localparam int NCELLS  = 9;
  localparam int BOARD_W = 2 * NCELLS;
  localparam int NLINES  = 8;

  // Address-width copy of NCELLS for range checks on 4-bit addresses
  localparam logic [3:0] NCELLS_A = 4'(NCELLS);

  typedef enum logic [1:0] {
    EMPTY     = 2'b00,
    CELL_X    = 2'b01,
    CELL_O    = 2'b10,
    CELL_RSVD = 2'b11
  } cell_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_WRITE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_EVAL   = 3'd4,
    ST_DONE   = 3'd5
  } mc_state_t;

  // Rows, columns, then the two diagonals
  localparam int WIN_LINES [NLINES][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  // Contents of one cell; out-of-range indices read as empty
  function automatic logic [1:0] cell_at(input logic [BOARD_W-1:0] board,
                                         input logic [3:0]         idx);
    logic [1:0] val;
    val = EMPTY;
    for (int i = 0; i < NCELLS; i++) begin
      if (idx == 4'(i)) val = board[2*i +: 2];
    end
    return val;
  endfunction

endpackage

`default_nettype wire

// File: rtl/move_ctrl_if.sv
// ============================================================================
// Module   : move_ctrl_if
// Purpose  : Bundle between the move controller, its request source and the
//            board memory. The slave side is the controller itself.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface move_ctrl_if
  import ttt_pkg::*;
();

  // Request side and board read-back
  logic                moveValid;
  logic [3:0]          moveAddr;
  logic [BOARD_W-1:0]  gBoard;

  // Board write port and game status
  logic [3:0]          addr;
  logic [1:0]          cellState;
  logic                turn;
  logic                busy;
  logic                illegal;
  logic [3:0]          moveCount;
  logic [1:0]          winner;
  logic                done;

  modport master (
    output moveValid, moveAddr, gBoard,
    input  addr, cellState, turn, busy, illegal, moveCount, winner, done
  );

  modport slave (
    input  moveValid, moveAddr, gBoard,
    output addr, cellState, turn, busy, illegal, moveCount, winner, done
  );

endinterface

`default_nettype wire

// File: rtl/move_ctrl_line_check.sv
// ============================================================================
// Module   : line_check
// Purpose  : Combinational three-in-a-line detector for one player code.
//            Reserved cells (11) and the empty code never count as a line.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_check
  import ttt_pkg::*;
(
  input  logic [BOARD_W-1:0] gBoard,
  input  logic [1:0]         player,
  output logic               win
);

  logic [NLINES-1:0] hits;

  for (genvar i = 0; i < NLINES; i++) begin : g_line
    // One line is complete when all three of its cells hold the player code
    assign hits[i] = (gBoard[2*WIN_LINES[i][0] +: 2] == player) &&
                     (gBoard[2*WIN_LINES[i][1] +: 2] == player) &&
                     (gBoard[2*WIN_LINES[i][2] +: 2] == player);
  end

  // Only real player codes can win; this keeps an all-empty line from matching
  assign win = ((player == CELL_X) || (player == CELL_O)) && (|hits);

endmodule

`default_nettype wire

// File: rtl/move_ctrl.sv
// ============================================================================
// Module   : move_ctrl
// Purpose  : Upstream write controller for the 9-cell board memory. Accepts
//            one move at a time, validates it against the read-back board,
//            issues a single write, then alternates turns and detects a win
//            or a draw.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module move_ctrl
  import ttt_pkg::*;
#(
  parameter logic [3:0] IDLE_ADDR = 4'hF
) (
  input  logic        ph1,
  input  logic        reset,
  move_ctrl_if.slave  bus
);

  mc_state_t  state;
  logic [3:0] req_addr;
  logic [1:0] player;
  logic       req_bad;
  logic       win_now;

  assign player = bus.turn ? CELL_O : CELL_X;

  // Legality is judged from the incoming request while the board is stable
  // in IDLE, so the registered reject pulse lands in the CHECK cycle.
  assign req_bad = (bus.moveAddr >= NCELLS_A) ||
                   (cell_at(bus.gBoard, bus.moveAddr) != EMPTY);

  line_check u_line_check (
    .gBoard (bus.gBoard),
    .player (player),
    .win    (win_now)
  );

  // Controller FSM with all outputs registered
  always_ff @(posedge ph1) begin
    if (!reset) begin
      state         <= ST_IDLE;
      req_addr      <= 4'd0;
      bus.addr      <= IDLE_ADDR;
      bus.cellState <= EMPTY;
      bus.turn      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.illegal   <= 1'b0;
      bus.moveCount <= 4'd0;
      bus.winner    <= WIN_NONE;
      bus.done      <= 1'b0;
    end else begin
      // The write port and reject pulse are single-cycle by default
      bus.addr      <= IDLE_ADDR;
      bus.cellState <= EMPTY;
      bus.illegal   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.moveValid) begin
            req_addr    <= bus.moveAddr;
            bus.illegal <= req_bad;
            bus.busy    <= 1'b1;
            state       <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (bus.illegal) begin
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            bus.addr      <= req_addr;
            bus.cellState <= player;
            state         <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          state <= ST_SETTLE;
        end

        // Gives the memory one cycle to reflect the write on gBoard
        ST_SETTLE: begin
          state <= ST_EVAL;
        end

        ST_EVAL: begin
          bus.turn <= ~bus.turn;
          if (bus.moveCount < NCELLS_A) begin
            bus.moveCount <= bus.moveCount + 4'd1;
          end
          if (win_now) begin
            bus.winner <= bus.turn ? WIN_O : WIN_X;
            bus.done   <= 1'b1;
            state      <= ST_DONE;
          end else if ((bus.moveCount + 4'd1) == NCELLS_A) begin
            bus.winner <= WIN_DRAW;
            bus.done   <= 1'b1;
            state      <= ST_DONE;
          end else begin
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end
        end

        // Game over: everything holds until reset
        ST_DONE: begin
          state <= ST_DONE;
        end

        default: begin
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_move_ctrl.sv
// ============================================================================
// Module   : tb_move_ctrl
// Purpose  : Self-checking bench for move_ctrl with a behavioural board
//            memory and a game-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_move_ctrl;
  import ttt_pkg::*;

  logic ph1;
  logic reset;

  move_ctrl_if bus ();

  move_ctrl #(.IDLE_ADDR(4'hF)) dut (
    .ph1   (ph1),
    .reset (reset),
    .bus   (bus)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  int tests_run    = 0;
  int tests_failed = 0;

  // Board memory model
  logic [1:0] mem [9];
  logic       mem_clear;
  logic       poke_en;
  logic [3:0] poke_addr;
  logic [1:0] poke_val;

  always @(posedge ph1) begin
    if (mem_clear) begin
      for (int i = 0; i < 9; i++) mem[i] <= 2'b00;
    end else if (poke_en) begin
      mem[poke_addr] <= poke_val;
    end else if (bus.cellState != 2'b00 && bus.addr < 4'd9) begin
      mem[bus.addr] <= bus.cellState;
    end
  end

  always_comb begin
    bus.gBoard = '0;
    for (int j = 0; j < 9; j++) bus.gBoard[2*j +: 2] = mem[j];
  end

  // Game reference model
  logic [1:0] mb [9];
  logic       m_turn;
  int         m_count;
  logic [1:0] m_win;
  logic       m_done;

  int LINES [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic bit model_line(input logic [1:0] p);
    for (int l = 0; l < 8; l++) begin
      if (mb[LINES[l][0]] == p && mb[LINES[l][1]] == p && mb[LINES[l][2]] == p)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) mb[i] = 2'b00;
    m_turn  = 1'b0;
    m_count = 0;
    m_win   = 2'b00;
    m_done  = 1'b0;
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    mem_clear = 1'b1;
    repeat (2) @(negedge ph1);
    reset     = 1'b1;
    mem_clear = 1'b0;
    model_reset();
  endtask

  // One request, observed over six cycles and checked against the model
  task automatic do_move(input logic [3:0] a, input string tag);
    bit         exp_legal, exp_ill;
    logic [1:0] code;
    int         guard, n_ill, ill_at, n_wr, wr_at;
    logic [3:0] wr_addr;
    logic [1:0] wr_data;
    bit         board_bad;

    guard = 0;
    while (!m_done && bus.busy && guard < 20) begin
      @(negedge ph1);
      guard++;
    end
    if (guard >= 20) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s idle_wait: busy stayed %0b, required 0", tag, bus.busy);
    end

    exp_legal = !m_done && (a < 4'd9) && (mb[a[3:0] % 9] == 2'b00);
    exp_ill   = !m_done && !exp_legal;
    code      = m_turn ? 2'b10 : 2'b01;

    n_ill = 0; ill_at = 0; n_wr = 0; wr_at = 0; wr_addr = 4'h0; wr_data = 2'b00;
    bus.moveValid = 1'b1;
    bus.moveAddr  = a;
    for (int k = 1; k <= 6; k++) begin
      @(negedge ph1);
      if (k == 1) bus.moveValid = 1'b0;
      if (bus.illegal) begin n_ill++; ill_at = k; end
      if (bus.cellState != 2'b00) begin
        n_wr++; wr_at = k; wr_addr = bus.addr; wr_data = bus.cellState;
      end
    end

    if (exp_legal) begin
      mb[a] = code;
      m_count++;
      if (model_line(code)) begin m_win = code; m_done = 1'b1; end
      else if (m_count == 9) begin m_win = 2'b11; m_done = 1'b1; end
      m_turn = ~m_turn;
    end

    tests_run++;
    if ({4'(n_ill), 4'(ill_at)} !== (exp_ill ? {4'd1, 4'd1} : 8'h00)) begin
      tests_failed++;
      $display("FAIL %s illegal: pulses=%0d at=%0d, required pulses=%0d at=%0d",
               tag, n_ill, ill_at, exp_ill ? 1 : 0, exp_ill ? 1 : 0);
    end

    tests_run++;
    if (exp_legal) begin
      if ({4'(n_wr), 4'(wr_at), wr_addr, wr_data} !== {4'd1, 4'd2, a, code}) begin
        tests_failed++;
        $display("FAIL %s write: n=%0d at=%0d addr=%0d data=%b, required n=1 at=2 addr=%0d data=%b",
                 tag, n_wr, wr_at, wr_addr, wr_data, a, code);
      end
    end else if (n_wr !== 0) begin
      tests_failed++;
      $display("FAIL %s write: n=%0d, required 0", tag, n_wr);
    end

    tests_run++;
    if ({bus.turn, bus.moveCount, bus.winner, bus.done, bus.busy} !==
        {m_turn, 4'(m_count), m_win, m_done, m_done}) begin
      tests_failed++;
      $display("FAIL %s status: turn=%0b cnt=%0d win=%b done=%0b busy=%0b, required turn=%0b cnt=%0d win=%b done=%0b busy=%0b",
               tag, bus.turn, bus.moveCount, bus.winner, bus.done, bus.busy,
               m_turn, m_count, m_win, m_done, m_done);
    end

    board_bad = 1'b0;
    for (int i = 0; i < 9; i++) if (mem[i] !== mb[i]) board_bad = 1'b1;
    tests_run++;
    if (board_bad) begin
      tests_failed++;
      $display("FAIL %s board: gBoard=%h differs from reference", tag, bus.gBoard);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if ({bus.addr, bus.cellState, bus.turn, bus.busy, bus.illegal, bus.moveCount, bus.winner, bus.done}
        !== {4'hF, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset: addr=%h cs=%b turn=%0b busy=%0b ill=%0b cnt=%0d win=%b done=%0b, required F/00/0/0/0/0/00/0",
               bus.addr, bus.cellState, bus.turn, bus.busy, bus.illegal,
               bus.moveCount, bus.winner, bus.done);
    end
  endtask

  task automatic test_first_and_illegal();
    apply_reset();
    do_move(4'd4, "first_x4");
    do_move(4'd4, "occupied_4");
    do_move(4'd9, "range_9");
    do_move(4'd15, "range_15");
  endtask

  task automatic test_win();
    logic [3:0] seq [5] = '{4'd0, 4'd3, 4'd1, 4'd4, 4'd2};
    apply_reset();
    foreach (seq[i]) do_move(seq[i], "win_seq");
    do_move(4'd8, "after_done");
    do_move(4'd0, "after_done_occ");
  endtask

  task automatic test_draw();
    logic [3:0] seq [9] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
    bit empty_seen;
    apply_reset();
    foreach (seq[i]) do_move(seq[i], "draw_seq");
    empty_seen = 1'b0;
    for (int i = 0; i < 9; i++) if (bus.gBoard[2*i +: 2] == 2'b00) empty_seen = 1'b1;
    tests_run++;
    if (empty_seen || bus.winner !== 2'b11) begin
      tests_failed++;
      $display("FAIL draw_full: gBoard=%h winner=%b, required no empty cell and winner 11",
               bus.gBoard, bus.winner);
    end
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    bus.moveValid = 1'b1;
    bus.moveAddr  = 4'd4;
    @(negedge ph1);
    bus.moveValid = 1'b0;
    @(negedge ph1);
    reset = 1'b0;
    @(negedge ph1);
    tests_run++;
    if ({bus.cellState, bus.addr, bus.busy, bus.moveCount, bus.turn} !==
        {2'b00, 4'hF, 1'b0, 4'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_mid_write: cs=%b addr=%h busy=%0b cnt=%0d turn=%0b, required 00/F/0/0/0",
               bus.cellState, bus.addr, bus.busy, bus.moveCount, bus.turn);
    end
    apply_reset();
    do_move(4'd4, "post_reset_x4");
  endtask

  task automatic test_busy_ignore();
    int n_wr;
    apply_reset();
    n_wr = 0;
    bus.moveValid = 1'b1;
    bus.moveAddr  = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge ph1);
      if (k == 1) bus.moveAddr = 4'd1;
      if (k == 4) bus.moveValid = 1'b0;
      if (bus.cellState != 2'b00) n_wr++;
    end
    tests_run++;
    if ({4'(n_wr), mem[0], mem[1], bus.moveCount, bus.busy} !==
        {4'd1, 2'b01, 2'b00, 4'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL busy_ignore: writes=%0d cell0=%b cell1=%b cnt=%0d busy=%0b, required 1/01/00/1/0",
               n_wr, mem[0], mem[1], bus.moveCount, bus.busy);
    end
  endtask

  task automatic test_reserved();
    apply_reset();
    poke_en = 1'b1; poke_addr = 4'd0; poke_val = 2'b11;
    @(negedge ph1);
    poke_addr = 4'd1;
    @(negedge ph1);
    poke_en = 1'b0;
    mb[0] = 2'b11;
    mb[1] = 2'b11;
    do_move(4'd2, "rsvd_no_line");
    do_move(4'd0, "rsvd_occupied");
    do_move(4'd5, "rsvd_o5");
  endtask

  task automatic test_random_games();
    for (int g = 0; g < 6; g++) begin
      apply_reset();
      for (int r = 0; r < 40 && !m_done; r++) begin
        do_move(4'($urandom_range(0, 10)), "random");
      end
      do_move(4'($urandom_range(0, 8)), "random_after");
    end
  endtask

  initial begin
    reset         = 1'b1;
    mem_clear     = 1'b0;
    poke_en       = 1'b0;
    poke_addr     = 4'd0;
    poke_val      = 2'b00;
    bus.moveValid = 1'b0;
    bus.moveAddr  = 4'd0;
    model_reset();
    @(negedge ph1);

    test_reset();
    test_first_and_illegal();
    test_win();
    test_draw();
    test_reset_mid_write();
    test_busy_ignore();
    test_reserved();
    test_random_games();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/move_ctrl.md
Name: move_ctrl

Overview:
- Upstream write controller for the 9-cell board memory (memArray).
- Accepts one player move request at a time, checks it against the current board read back from memArray, and issues a single write (addr, cellState).
- Alternates turns, counts moves, and detects win or draw.
- Drives memArray's addr/cellState write inputs; consumes its gBoard output.

Parameters:
- NCELLS, 9, number of board cells (addr values 0..NCELLS-1 are valid).
- IDLE_ADDR, 4'hF, address driven when no write is pending; memArray ignores addr >= NCELLS.

Ports:
- ph1  input  1  single system clock; all state updates on posedge ph1.
- reset  input  1  synchronous, active-low reset; sampled on posedge ph1.
- moveValid  input  1  move request strobe; sampled only in IDLE.
- moveAddr  input  4  requested cell, 0..8.
- gBoard  input  18  board from memArray; cell i = gBoard[2i+1:2i]. Encoding: 00 empty, 01 X, 10 O, 11 reserved.
- addr  output  4  memArray write address.
- cellState  output  2  memArray write data; 00 = no write.
- turn  output  1  player to move: 0 = X, 1 = O.
- busy  output  1  high in any state other than IDLE.
- illegal  output  1  one-cycle pulse when a request is rejected.
- moveCount  output  4  accepted moves, 0..9.
- winner  output  2  00 none, 01 X, 10 O, 11 draw.
- done  output  1  game over; sticky until reset.

Behaviour:
- Reset (reset==0 at posedge ph1):
  - state=IDLE, addr=IDLE_ADDR, cellState=00, turn=0, busy=0, illegal=0, moveCount=0, winner=00, done=0.
  - Reset takes effect from any state, including mid-write. No partial write survives: cellState is 00 on the cycle after reset.
- FSM states: IDLE, CHECK, WRITE, SETTLE, EVAL, DONE.
- IDLE:
  - moveValid=1 latches moveAddr into reqAddr and goes to CHECK.
  - moveValid=0 stays in IDLE.
- CHECK: a request is illegal if reqAddr >= NCELLS or gBoard cell reqAddr != 00.
  - Illegal: illegal=1 for exactly this cycle; go to IDLE; turn and moveCount unchanged.
  - Legal: go to WRITE.
- WRITE:
  - addr=reqAddr and cellState=(turn ? 10 : 01) for exactly one cycle.
  - Go to SETTLE.
  - In all other states: addr=IDLE_ADDR, cellState=00.
- SETTLE: one wait cycle so memArray's updated gBoard is visible. Go to EVAL.
- EVAL: evaluate the 8 lines: rows {0,1,2},{3,4,5},{6,7,8}; cols {0,3,6},{1,4,7},{2,5,8}; diagonals {0,4,8},{2,4,6}.
  - Line complete for the current player: winner = that player's code, done=1, go to DONE.
  - Else if moveCount+1 == 9: winner=11, done=1, go to DONE.
  - Else go to IDLE.
  - In every case moveCount increments and turn toggles on the exit from EVAL.
- DONE: all requests ignored; no illegal pulse; outputs frozen until reset.
- Latency: legal request accepted at edge N; write driven in cycle N+2; result (turn/moveCount/winner) visible after edge N+4.
- Illegal request: pulse appears in the cycle after acceptance. Back-to-back requests are possible one cycle after returning to IDLE.
- moveValid while busy=1 is ignored. It is not queued.
- moveCount saturates at 9 and never wraps.
- gBoard 11 in a cell counts as occupied and never completes a line.

Decomposition:
- Package ttt_pkg:
  - cell_t encoding (EMPTY=2'b00, CELL_X=2'b01, CELL_O=2'b10).
  - NCELLS.
  - winner codes (WIN_NONE, WIN_X, WIN_O, WIN_DRAW).
  - mc_state_t enum.
  - WIN_LINES constant (8x3 cell indices).
- Sub-module line_check (combinational): gBoard and player code in, 1-bit "has three in a line" out. Reused later by an AI/display stage.

Test Plan:
- Reset with reset=0 for 2 cycles, then 1 -> addr=4'hF, cellState=00, turn=0, moveCount=0, winner=00, done=0, busy=0.
- moveAddr=4 on empty board -> exactly one cycle with addr=4, cellState=01; afterwards turn=1, moveCount=1, winner=00.
- After X at 4, request moveAddr=4 -> illegal=1 for one cycle, no write cycle, turn stays 1, moveCount stays 1. Request moveAddr=9 -> same result.
- Sequence X0,O3,X1,O4,X2 -> after the fifth EVAL: winner=01, done=1, moveCount=5. A further moveValid produces no write and no illegal pulse.
- Full draw X0,O1,X2,O4,X3,O5,X7,O6,X8 -> winner=11, done=1, moveCount=9, gBoard has no empty cell.
- Reset asserted during a WRITE cycle -> next cycle cellState=00, state IDLE, moveCount=0. moveValid pulsed while busy -> ignored, only one write observed.
